serial_addsub16: RTL

- Bit-serial, multi-cycle counterpart to the 16-bit ripple-carry adder. It computes A+B+cin or A−B, LSB first, one bit per clock, through a single full-adder cell and a carry flop.
- Used where area matters more than latency. Its results are checked against the combinational adder for the same operands.
- Start/done handshake. Operands are captured at start; the result is held until the next start.

---
 rtl/serial_addsub16.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/serial_addsub16.sv
// ---------------------------------------------------------------------------
// serial_addsub16
//
// Bit-serial adder/subtractor. A single full-adder cell and a carry flop
// process one bit per clock, LSB first. It computes A+B+cin, or A-B as
// A+~B+1. A start/done handshake surrounds each operation. Operands are
// captured on the start edge. The result registers update only at the
// completion edge, so they hold their value between operations.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, sampled only while busy=0
//   sub    in   1      0 = add (A+B+cin), 1 = subtract (A+~B+1)
//   a      in   WIDTH  operand A
//   b      in   WIDTH  operand B
//   cin    in   1      carry-in for add, ignored when sub=1
//   busy   out  1      operation in progress
//   done   out  1      one-cycle pulse, result valid
//   s      out  WIDTH  result, held between operations
//   cout   out  1      final carry (for sub: 1 = no borrow)
//   ovf    out  1      two's-complement overflow of the result
// ---------------------------------------------------------------------------
module serial_addsub16 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state, next_state;
    logic              load, step, last;

    logic [WIDTH-1:0]  op_a, op_b, acc;
    logic              carry;
    logic [CNT_W-1:0]  cnt;
    logic              sign_a, sign_b;

    // Full-adder cell. It operates on the current LSBs of the operand shift registers.
    logic              sum_bit, carry_next;
    logic [WIDTH-1:0]  acc_next;

    assign sum_bit    = op_a[0] ^ op_b[0] ^ carry;
    assign carry_next = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    assign acc_next   = {sum_bit, acc[WIDTH-1:1]};

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode.
    // NOTE: every signal gets a default before the case, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    // Serial datapath: the operand shift registers, the carry flop, the bit counter
    // and the partial-sum accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
        end else if (load) begin
            op_a   <= a;
            op_b   <= sub ? ~b : b;
            acc    <= '0;
            carry  <= sub ? 1'b1 : cin;
            cnt    <= '0;
            sign_a <= a[WIDTH-1];
            sign_b <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
        end else if (step) begin
            op_a   <= op_a >> 1;
            op_b   <= op_b >> 1;
            acc    <= acc_next;
            carry  <= carry_next;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // Visible results. These change only at the completion edge, so partial sums
    // never reach s. done is re-evaluated on every edge, which makes it
    // a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s    <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= last;
            if (last) begin
                s    <= acc_next;
                cout <= carry_next;
                // The operand signs match, but the result sign differs from them.
                ovf  <= (sign_a == sign_b) && (sum_bit != sign_a);
            end
        end
    end

endmodule
